display_tx: RTL and testbench
=============================

DISPLAY_TX -- requirements
Module: display_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, gives the Clk cycles per serial bit; legal range 2..65535.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 DDR_WE  input  1  write strobe for the LC-3 display data register (DDR), sampled on the rising edge of Clk.
REQ-005 DDR_In  input  16  DDR write data; only bits [7:0] are transmitted, and bits [15:8] are ignored.
REQ-006 DSR_Out  output  16  display status register: bit 15 = ready, bits [14:0] = 0.
REQ-007 TX  output  1  serial line, 8N1, idle high, registered.
REQ-008 Busy  output  1  high whenever a frame is in progress (state is not IDLE).

Function
REQ-009 The transmitter SHALL be an FSM with states IDLE, START, DATA and STOP.
REQ-010 Accept = DDR_WE && DSR_Out[15] at a rising edge; a write while DSR_Out[15]=0 SHALL be discarded with no state change.
REQ-011 An accept in IDLE SHALL, at that same edge, load the byte into the shift register, enter START and drive TX=0, so TX goes low one cycle after the strobe.
REQ-012 START SHALL hold TX=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-013 DATA SHALL send bits 0..7 LSB-first, each for exactly CLKS_PER_BIT cycles, using a 3-bit bit index and a baud counter wide enough for CLKS_PER_BIT-1.
REQ-014 STOP SHALL hold TX=1 for CLKS_PER_BIT cycles; a frame lasts exactly 10*CLKS_PER_BIT cycles.
REQ-015 On leaving STOP with a character pending, the FSM SHALL enter START directly, giving back-to-back frames with no idle gap; with nothing pending it SHALL enter IDLE.
REQ-016 In IDLE, TX SHALL be 1 and Busy SHALL be 0.
REQ-017 DSR_Out[15] SHALL be registered and SHALL reflect buffer space available for the next cycle.

Reset
REQ-018 Reset SHALL immediately force state=IDLE, TX=1, Busy=0, DSR_Out=16'h8000, counters=0 and buffer empty, including when asserted mid-frame.
REQ-019 The first accept after Reset deasserts SHALL start a complete, fresh frame.

Configuration
REQ-020 Macro DISPLAY_TX_FIFO_EN, when defined, SHALL add a 4-entry FIFO.
- DSR_Out[15] = 1 while fewer than 4 bytes are queued, not counting the byte being shifted.
- A write during STOP's last cycle with an empty FIFO SHALL be queued and sent back-to-back.
- FIFO full: the write is discarded.
REQ-021 Without DISPLAY_TX_FIFO_EN, DSR_Out[15] SHALL be 1 only in IDLE; no character is pending, and every frame is followed by IDLE.

Structure
REQ-022 Package display_tx_pkg SHALL hold:
- the FSM state enum;
- DISPLAY_TX_CLKS_PER_BIT_DEFAULT = 16;
- DISPLAY_TX_FIFO_DEPTH = 4.
REQ-023 The FIFO SHALL be the sub-module display_tx_fifo (synchronous, 8-bit, depth from package, full/empty flags), instantiated only under DISPLAY_TX_FIFO_EN.

Verification
REQ-024 CLKS_PER_BIT=4, write 8'h41 -> TX samples 0,1,0,0,0,0,0,1,0,1 at 4-cycle spacing; DSR_Out returns to 16'h8000 after 40 cycles.
REQ-025 Write 8'h55, then write 8'hAA during the frame (no FIFO) -> only 8'h55 is seen on TX; 8'hAA is dropped.
REQ-026 FIFO build: 5 back-to-back writes 8'h01..8'h05 -> 5 frames with no idle gap; DSR_Out[15]=0 after the fifth write until the first frame completes.
REQ-027 Assert Reset during DATA bit 3 -> TX=1 and DSR_Out=16'h8000 in the same cycle; the next write produces a clean full frame.
REQ-028 DDR_In=16'hFF5A -> transmitted byte is 8'h5A.
REQ-029 Hold DDR_WE high for 3 cycles with one byte (no FIFO) -> exactly one frame is sent.

Source files
------------

// File: rtl/display_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_tx_pkg
// Brief    : Shared types and constants for the LC-3 display transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package display_tx_pkg;

    localparam int DISPLAY_TX_CLKS_PER_BIT_DEFAULT = 16;
    localparam int DISPLAY_TX_FIFO_DEPTH           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/display_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : display_tx_fifo
// Brief    : Small show-ahead FIFO queuing characters behind the active frame.
// Revision : 1.0 - initial release
// ============================================================================
module display_tx_fifo
    import display_tx_pkg::*;
#(
    parameter int DEPTH = DISPLAY_TX_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_tx.sv
`default_nettype none
// ============================================================================
// Module   : display_tx
// Brief    : LC-3 display data register driving an 8N1 serial line.
//            Define DISPLAY_TX_FIFO_EN to queue up to 4 characters.
// Revision : 1.0 - initial release
// ============================================================================
module display_tx
    import display_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DISPLAY_TX_CLKS_PER_BIT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        DDR_WE,
    input  logic [15:0] DDR_In,
    output logic [15:0] DSR_Out,
    output logic        TX,
    output logic        Busy
);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t           r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_busy;
    logic                r_ready;

    logic                w_accept;
    logic                w_baud_done;
    logic                w_frame_end;
    logic                w_load;
    logic                w_ready_next;
    logic [7:0]          w_next_byte;
    logic                w_unused_hi;

    assign w_accept    = DDR_WE && r_ready;
    assign w_baud_done = (r_baud == c_BAUD_LAST);
    assign w_frame_end = (r_state == ST_STOP) && w_baud_done;
    assign w_unused_hi = ^DDR_In[15:8];

`ifdef DISPLAY_TX_FIFO_EN
    localparam int c_CNT_W = $clog2(DISPLAY_TX_FIFO_DEPTH + 1);

    logic               w_direct;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [7:0]         w_fifo_data;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic [c_CNT_W-1:0] w_count_next;

    // A write bypasses the queue when the shifter would otherwise go idle.
    assign w_direct     = w_accept && ((r_state == ST_IDLE) || (w_frame_end && w_fifo_empty));
    assign w_push       = w_accept && !w_direct && !w_fifo_full;
    assign w_pop        = w_frame_end && !w_fifo_empty;
    assign w_load       = w_direct || w_pop;
    assign w_next_byte  = w_direct ? DDR_In[7:0] : w_fifo_data;
    assign w_count_next = w_fifo_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_ready_next = (w_count_next < c_CNT_W'(DISPLAY_TX_FIFO_DEPTH));

    display_tx_fifo #(
        .DEPTH (DISPLAY_TX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (DDR_In[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );
`else
    assign w_load       = w_accept && (r_state == ST_IDLE);
    assign w_next_byte  = DDR_In[7:0];
    assign w_ready_next = ((r_state == ST_IDLE) && !w_accept) || w_frame_end;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_ready <= w_ready_next;
            case (r_state)
                ST_IDLE: begin
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    if (w_load) begin
                        r_shift <= w_next_byte;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        // A pending character restarts immediately: no idle gap.
                        if (w_load) begin
                            r_shift <= w_next_byte;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX      = r_tx;
    assign Busy    = r_busy;
    assign DSR_Out = {r_ready, 15'b0};

endmodule
`default_nettype wire

// File: tb/tb_display_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_tx
// Brief    : Self-checking bench for display_tx (CLKS_PER_BIT = 4); honours
//            DISPLAY_TX_FIFO_EN. Reference model is a queue of line levels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_tx;
    localparam int C = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        DDR_WE;
    logic [15:0] DDR_In;
    logic [15:0] DSR_Out;
    logic        TX;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected line level per future cycle, plus queued bytes.
    bit       m_line [$];
    bit [7:0] m_pend [$];
    bit       m_ready;

    display_tx #(.CLKS_PER_BIT(C)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .DDR_WE  (DDR_WE),
        .DDR_In  (DDR_In),
        .DSR_Out (DSR_Out),
        .TX      (TX),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_line.delete();
        m_pend.delete();
        m_ready = 1'b1;
    endtask

    task automatic append_frame(input bit [7:0] b);
        for (int k = 0; k < C; k++) m_line.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < C; k++) m_line.push_back(b[i]);
        for (int k = 0; k < C; k++) m_line.push_back(1'b1);
    endtask

    task automatic model_step(input bit we, input logic [15:0] din);
        bit acc;
        if (m_line.size() > 0) void'(m_line.pop_front());
        acc = we && m_ready;
`ifdef DISPLAY_TX_FIFO_EN
        if (acc) m_pend.push_back(din[7:0]);
        if (m_line.size() == 0 && m_pend.size() > 0) append_frame(m_pend.pop_front());
        m_ready = (m_pend.size() < 4);
`else
        if (acc) append_frame(din[7:0]);
        m_ready = (m_line.size() == 0);
`endif
    endtask

    task automatic check_model();
        chk("tx",   {15'b0, TX},   {15'b0, (m_line.size() > 0) ? m_line[0] : 1'b1});
        chk("busy", {15'b0, Busy}, {15'b0, (m_line.size() > 0)});
        chk("dsr",  DSR_Out,       {m_ready, 15'b0});
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Reset) model_clear();
        else model_step(DDR_WE, DDR_In);
        @(negedge Clk);
        check_model();
    endtask

    // Writes din, samples each bit mid-cell; optional extra strobes at index extra_at.
    task automatic send_frame(input logic [15:0] din, input int extra_at, input int extra_len,
                              input logic [15:0] extra_din, output logic [9:0] samples,
                              output logic [15:0] dsr_last, output logic [15:0] dsr_end);
        DDR_WE = 1'b1;
        DDR_In = din;
        cycle();
        DDR_WE = 1'b0;
        for (int i = 0; i <= 10 * C; i++) begin
            if (i % C == C / 2) samples[i / C] = TX;
            if (i == 10 * C - 1) dsr_last = DSR_Out;
            if (i == 10 * C) dsr_end = DSR_Out;
            if (i < 10 * C) begin
                DDR_WE = (i >= extra_at) && (i < extra_at + extra_len);
                if (DDR_WE) DDR_In = extra_din;
                cycle();
                DDR_WE = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [15:0] din;
        logic [7:0]  exp_byte;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [9:0]  smp;
        logic [15:0] d_last, d_end;
        logic [15:0] exp_busy_dsr;
        int          gaps;

        vecs[0] = '{16'h0041, 8'h41};
        vecs[1] = '{16'hFF5A, 8'h5A};
        vecs[2] = '{16'h8055, 8'h55};
        vecs[3] = '{16'h00FF, 8'hFF};
        vecs[4] = '{16'hAB00, 8'h00};
`ifdef DISPLAY_TX_FIFO_EN
        exp_busy_dsr = 16'h8000;
`else
        exp_busy_dsr = 16'h0000;
`endif

        Reset  = 1'b1;
        DDR_WE = 1'b0;
        DDR_In = 16'h0000;
        model_clear();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset tx",   {15'b0, TX},   16'h0001);
        chk("reset busy", {15'b0, Busy}, 16'h0000);
        chk("reset dsr",  DSR_Out,       16'h8000);
        Reset = 1'b0;
        cycle();

        // Directed frames: sampled line must be start, LSB-first byte, stop.
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].din, 1000, 0, 16'h0, smp, d_last, d_end);
            chk($sformatf("frame[%0d]", v), {6'b0, smp}, {6'b0, 1'b1, vecs[v].exp_byte, 1'b0});
            chk($sformatf("dsr in frame[%0d]", v), d_last, exp_busy_dsr);
            chk($sformatf("dsr after frame[%0d]", v), d_end, 16'h8000);
        end

`ifndef DISPLAY_TX_FIFO_EN
        // Write during a frame is dropped.
        send_frame(16'h0055, 10, 1, 16'h00AA, smp, d_last, d_end);
        chk("drop frame", {6'b0, smp}, {6'b0, 1'b1, 8'h55, 1'b0});
        repeat (6) cycle();
        chk("drop idle busy", {15'b0, Busy}, 16'h0000);

        // Strobe held for three cycles sends one frame.
        send_frame(16'h0077, 0, 2, 16'h0077, smp, d_last, d_end);
        chk("hold frame", {6'b0, smp}, {6'b0, 1'b1, 8'h77, 1'b0});
        repeat (6) cycle();
        chk("hold idle busy", {15'b0, Busy}, 16'h0000);
        chk("hold idle tx",   {15'b0, TX},   16'h0001);
`else
        // Five back-to-back writes: one shifting, four queued.
        for (int k = 1; k <= 5; k++) begin
            DDR_WE = 1'b1;
            DDR_In = 16'(k);
            cycle();
        end
        DDR_WE = 1'b0;
        chk("fifo full dsr", DSR_Out, 16'h0000);
        gaps = 0;
        for (int i = 5; i <= 50 * C; i++) begin
            if (i == 10 * C - 1) chk("fifo dsr before pop", DSR_Out, 16'h0000);
            if (i == 10 * C)     chk("fifo dsr after pop",  DSR_Out, 16'h8000);
            if (i < 50 * C && !Busy) gaps++;
            if (i < 50 * C) cycle();
        end
        chk("fifo idle gaps", 16'(gaps), 16'h0000);
        chk("fifo end busy", {15'b0, Busy}, 16'h0000);
`endif

        // Reset asserted during data bit 3 takes effect at once.
        DDR_WE = 1'b1;
        DDR_In = 16'h00C3;
        cycle();
        DDR_WE = 1'b0;
        repeat (4 * C + 1) cycle();
        chk("bit3 tx before reset", {15'b0, TX}, 16'h0000);
        #1 Reset = 1'b1;
        #1;
        chk("mid reset tx",   {15'b0, TX},   16'h0001);
        chk("mid reset dsr",  DSR_Out,       16'h8000);
        chk("mid reset busy", {15'b0, Busy}, 16'h0000);
        model_clear();
        cycle();
        Reset = 1'b0;
        cycle();
        send_frame(16'h003C, 1000, 0, 16'h0, smp, d_last, d_end);
        chk("post reset frame", {6'b0, smp}, {6'b0, 1'b1, 8'h3C, 1'b0});
        chk("post reset dsr", d_end, 16'h8000);

        // Random traffic against the model, with rare resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                Reset = 1'b1;
                cycle();
                Reset = 1'b0;
            end
            DDR_WE = ($urandom_range(0, 7) == 0);
            DDR_In = 16'($urandom);
            cycle();
        end
        DDR_WE = 1'b0;
        repeat (60 * C) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
